// File: rtl/vvadd_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM among the A/B/C
// memory channels of a vvadd PE: one grant per cycle, one response per request.
module vvadd_mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int REQ_W  = ADDR_W + DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req_a,
  input  logic [REQ_W-1:0]  req_b,
  input  logic [REQ_W-1:0]  req_c,
  input  logic              req_a_vld,
  input  logic              req_b_vld,
  input  logic              req_c_vld,
  output logic              req_a_rdy,
  output logic              req_b_rdy,
  output logic              req_c_rdy,
  output logic [DATA_W-1:0] resp_a,
  output logic [DATA_W-1:0] resp_b,
  output logic [DATA_W-1:0] resp_c,
  output logic              resp_a_vld,
  output logic              resp_b_vld,
  output logic              resp_c_vld,
  input  logic              resp_a_rdy,
  input  logic              resp_b_rdy,
  input  logic              resp_c_rdy,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [1:0] PORT_C = 2'd2;

  logic [2:0]        req_vld;
  logic [2:0]        resp_rdy;
  logic [2:0]        elig;
  logic [3:0]        elig_ext;
  logic [2:0]        gnt;
  logic [2:0]        busy;
  logic [2:0]        resp_vld;
  logic [2:0]        xfer;
  logic [2:0]        cap;
  logic [1:0]        last;
  logic [1:0]        cand;
  logic [1:0]        win;
  logic              win_vld;
  logic [REQ_W-1:0]  win_pl;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_wr;
  logic              f_vld;
  logic              f_wr;
  logic [1:0]        f_port;
  logic [DATA_W-1:0] resp_q [3];

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == PORT_C) ? 2'd0 : p + 2'd1;
  endfunction

  // op = {wr, rd}; any request with wr set is a write, everything else reads
  function automatic logic op_is_write(input logic [1:0] op);
    logic w;
    casez (op)
      2'b1?:   w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  assign req_vld  = {req_c_vld, req_b_vld, req_a_vld};
  assign resp_rdy = {resp_c_rdy, resp_b_rdy, resp_a_rdy};
  assign elig     = req_vld & ~busy;
  assign elig_ext = {1'b0, elig};

  // Round-robin search starting one past the last winner
  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    cand    = next_port(last);
    for (int i = 0; i < 3; i++) begin
      if (!win_vld && elig_ext[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
      cand = next_port(cand);
    end
    if (rst) win_vld = 1'b0;
  end

  assign gnt = win_vld ? (3'b001 << win) : 3'b000;

  always_comb begin
    case (win)
      2'd0:    win_pl = req_a;
      2'd1:    win_pl = req_b;
      default: win_pl = req_c;
    endcase
  end

  assign win_addr = win_pl[REQ_W-1 -: ADDR_W];
  assign win_data = win_pl[DATA_W+1:2];
  assign win_wr   = op_is_write(win_pl[1:0]);

  assign sram_en    = win_vld;
  assign sram_we    = win_vld & win_wr;
  assign sram_addr  = win_vld ? win_addr : '0;
  assign sram_wdata = win_vld ? win_data : '0;

  assign xfer = resp_vld & resp_rdy;
  assign cap  = f_vld ? (3'b001 << f_port) : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      last     <= PORT_C;
      f_vld    <= 1'b0;
      f_wr     <= 1'b0;
      f_port   <= 2'd0;
      resp_vld <= '0;
      for (int p = 0; p < 3; p++) resp_q[p] <= '0;
    end else begin
      // Grant stage: SRAM captures the access on this edge
      busy   <= (busy & ~xfer) | gnt;
      f_vld  <= win_vld;
      f_wr   <= win_wr;
      f_port <= win;
      if (win_vld) last <= win;
      // Capture stage: read data (or a zero write ack) lands in the port's register
      resp_vld <= (resp_vld & ~xfer) | cap;
      for (int p = 0; p < 3; p++) begin
        if (cap[p]) resp_q[p] <= f_wr ? '0 : sram_rdata;
      end
    end
  end

  assign req_a_rdy  = gnt[0];
  assign req_b_rdy  = gnt[1];
  assign req_c_rdy  = gnt[2];
  assign resp_a_vld = resp_vld[0];
  assign resp_b_vld = resp_vld[1];
  assign resp_c_vld = resp_vld[2];
  assign resp_a     = resp_q[0];
  assign resp_b     = resp_q[1];
  assign resp_c     = resp_q[2];

endmodule

// File: tb/tb_vvadd_mem_arbiter.sv
// Bench for vvadd_mem_arbiter: directed vector table, hand sequences for
// backpressure/reset, and a randomized run against a transaction-level model.
module tb_vvadd_mem_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int REQ_W  = ADDR_W + DATA_W + 2;

  logic clk = 1'b0;
  logic rst;
  logic [REQ_W-1:0]  pl [3];
  logic [2:0]        vld;
  logic [2:0]        rrdy;
  logic              req_a_rdy, req_b_rdy, req_c_rdy;
  logic [DATA_W-1:0] resp_a, resp_b, resp_c;
  logic              resp_a_vld, resp_b_vld, resp_c_vld;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] mem [128];

  logic [2:0]        rdy;
  logic [2:0]        rv;
  logic [DATA_W-1:0] rdat [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vvadd_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_a(pl[0]), .req_b(pl[1]), .req_c(pl[2]),
    .req_a_vld(vld[0]), .req_b_vld(vld[1]), .req_c_vld(vld[2]),
    .req_a_rdy(req_a_rdy), .req_b_rdy(req_b_rdy), .req_c_rdy(req_c_rdy),
    .resp_a(resp_a), .resp_b(resp_b), .resp_c(resp_c),
    .resp_a_vld(resp_a_vld), .resp_b_vld(resp_b_vld), .resp_c_vld(resp_c_vld),
    .resp_a_rdy(rrdy[0]), .resp_b_rdy(rrdy[1]), .resp_c_rdy(rrdy[2]),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  assign rdy     = {req_c_rdy, req_b_rdy, req_a_rdy};
  assign rv      = {resp_c_vld, resp_b_vld, resp_a_vld};
  assign rdat[0] = resp_a;
  assign rdat[1] = resp_b;
  assign rdat[2] = resp_c;

  // Single-port synchronous SRAM macro
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    sram_rdata = '0;
  end
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  function automatic logic [REQ_W-1:0] pack(input logic [6:0] a, input logic [31:0] d,
                                            input logic wr, input logic rd);
    return {a, d, wr, rd};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain();
    vld  = 3'b000;
    rrdy = 3'b111;
    repeat (4) begin #1; tick(); end
  endtask

  // One isolated request: grant now, silent next cycle, response two cycles after grant
  task automatic do_txn(input int port, input logic wr, input logic rd, input logic [6:0] addr,
                        input logic [31:0] data, input logic [31:0] exp);
    pl[port] = pack(addr, data, wr, rd);
    vld  = 3'b001 << port;
    rrdy = 3'b111;
    #1;
    chk("txn_gnt", rdy, 3'b001 << port);
    chk("txn_sram", {sram_en, sram_we, sram_addr, sram_wdata}, {1'b1, wr, addr, data});
    tick();
    vld = 3'b000;
    #1;
    chk("txn_early", rv, 3'b000);
    tick();
    #1;
    chk("txn_vld", rv, 3'b001 << port);
    chk("txn_data", rdat[port], exp);
    tick();
    #1;
    chk("txn_clr", rv, 3'b000);
    tick();
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic        rd;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  // Transaction-level reference state for the random run
  logic [31:0] ref_mem [128];
  logic [2:0]  mbusy;
  int          mdue [3];
  logic [31:0] mexp [3];
  int          mlast;

  initial begin
    tbl[0] = '{0, 1'b1, 1'b0, 7'h05, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1, 1'b0, 1'b1, 7'h05, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{0, 1'b1, 1'b1, 7'h7F, 32'h1,        32'h0};
    tbl[3] = '{2, 1'b0, 1'b0, 7'h7F, 32'h0,        32'h1};
    tbl[4] = '{2, 1'b1, 1'b0, 7'h00, 32'hA5A55A5A, 32'h0};
    tbl[5] = '{1, 1'b0, 1'b1, 7'h00, 32'h0,        32'hA5A55A5A};
    tbl[6] = '{0, 1'b0, 1'b1, 7'h7F, 32'h0,        32'h1};
    tbl[7] = '{1, 1'b1, 1'b1, 7'h7F, 32'h12345678, 32'h0};
    tbl[8] = '{0, 1'b0, 1'b1, 7'h7F, 32'hFFFF0000, 32'h12345678};

    rst  = 1'b1;
    vld  = 3'b000;
    rrdy = 3'b111;
    for (int p = 0; p < 3; p++) pl[p] = '0;
    tick();
    repeat (3) tick();

    // Reset defaults, then A wins the first three-way contest
    rst = 1'b0;
    #1;
    chk("rst_rdy", rdy, 3'b000);
    chk("rst_resp_vld", rv, 3'b000);
    chk("rst_resp_data", {rdat[0] | rdat[1] | rdat[2]}, 0);
    chk("rst_sram", {sram_en, sram_we, sram_addr, sram_wdata}, 0);
    tick();
    for (int p = 0; p < 3; p++) pl[p] = pack(7'h20 + 7'(p), 32'h0, 1'b0, 1'b1);
    vld = 3'b111;
    #1;
    chk("rst_first_gnt", rdy, 3'b001);
    tick();
    drain();

    for (int i = 0; i < 9; i++)
      do_txn(tbl[i].port, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].exp);

    // Round-robin with all ports continuously valid
    rst = 1'b1;
    vld = 3'b000;
    #1; tick();
    rst = 1'b0;
    for (int p = 0; p < 3; p++) pl[p] = pack(7'h10 + 7'(p), 32'h0, 1'b0, 1'b1);
    vld  = 3'b111;
    rrdy = 3'b111;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("rr_gnt", rdy, 3'b001 << (k % 3));
      chk("rr_en", sram_en, 1'b1);
      if (k >= 2) chk("rr_resp_vld", rv, 3'b001 << ((k + 1) % 3));
      tick();
    end
    drain();

    // Backpressure on C: A/B continue, C stays parked until its response drains
    pl[0] = pack(7'h10, 32'h0, 1'b0, 1'b1);
    pl[1] = pack(7'h11, 32'h0, 1'b0, 1'b1);
    pl[2] = pack(7'h05, 32'h0, 1'b0, 1'b1);
    vld  = 3'b100;
    rrdy = 3'b011;
    #1;
    chk("bp_c_gnt", rdy, 3'b100);
    tick();
    for (int j = 1; j <= 6; j++) begin
      vld = 3'b111;
      #1;
      chk("bp_gnt", rdy, (j % 3 == 1) ? 3'b001 : (j % 3 == 2) ? 3'b010 : 3'b000);
      if (j >= 2) begin
        chk("bp_c_vld", rv[2], 1'b1);
        chk("bp_c_data", rdat[2], 32'hDEADBEEF);
      end
      tick();
    end
    vld  = 3'b100;
    rrdy = 3'b111;
    #1;
    chk("bp_release_gnt", rdy, 3'b000);
    chk("bp_release_vld", rv[2], 1'b1);
    tick();
    #1;
    chk("bp_regrant", rdy, 3'b100);
    chk("bp_c_cleared", rv[2], 1'b0);
    tick();
    drain();

    // Reset the cycle after an A read is granted
    pl[0] = pack(7'h05, 32'h0, 1'b0, 1'b1);
    vld = 3'b001;
    #1;
    chk("mr_gnt", rdy, 3'b001);
    tick();
    rst = 1'b1;
    vld = 3'b000;
    for (int j = 0; j < 7; j++) begin
      if (j == 3) rst = 1'b0;
      #1;
      chk("mr_no_resp", rv, 3'b000);
      tick();
    end
    do_txn(0, 1'b0, 1'b1, 7'h05, 32'h0, 32'hDEADBEEF);
    do_txn(2, 1'b0, 1'b1, 7'h00, 32'h0, 32'hA5A55A5A);

    // Randomized traffic against the transaction model
    rst = 1'b1;
    vld = 3'b000;
    #1; tick();
    rst = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    mbusy = 3'b000;
    mlast = 2;
    for (int p = 0; p < 3; p++) begin mdue[p] = 0; mexp[p] = '0; end
    for (int n = 0; n < 400; n++) begin
      int w;
      logic [6:0] a;
      logic [2:0] ev;
      for (int p = 0; p < 3; p++) begin
        vld[p]  = ($urandom % 4) != 0;
        rrdy[p] = ($urandom % 4) != 0;
        pl[p]   = pack(7'h40 | 7'($urandom % 8), $urandom, 1'($urandom % 2), 1'($urandom % 2));
      end
      #1;
      w = -1;
      for (int i = 1; i <= 3; i++) begin
        int q;
        q = (mlast + i) % 3;
        if (w < 0 && vld[q] && !mbusy[q]) w = q;
      end
      chk("rnd_gnt", rdy, (w < 0) ? 3'b000 : (3'b001 << w));
      if (w >= 0)
        chk("rnd_sram", {sram_en, sram_we, sram_addr, sram_wdata},
            {1'b1, pl[w][1], pl[w][REQ_W-1 -: ADDR_W], pl[w][DATA_W+1:2]});
      else
        chk("rnd_sram_idle", {sram_en, sram_we, sram_addr, sram_wdata}, 0);
      for (int p = 0; p < 3; p++) begin
        ev[p] = mbusy[p] && (n >= mdue[p]);
        chk("rnd_resp_vld", rv[p], ev[p]);
        if (ev[p]) chk("rnd_resp_data", rdat[p], mexp[p]);
        if (ev[p] && rrdy[p]) mbusy[p] = 1'b0;
      end
      if (w >= 0) begin
        a = pl[w][REQ_W-1 -: ADDR_W];
        mbusy[w] = 1'b1;
        mdue[w]  = n + 2;
        if (pl[w][1]) begin
          mexp[w]    = '0;
          ref_mem[a] = pl[w][DATA_W+1:2];
        end else begin
          mexp[w] = ref_mem[a];
        end
        mlast = w;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
